// File: rtl/xunit_w_gen_if.sv
// Bus bundle for xunit_w_gen: run/delay0 configuration, message word in, (W_t, K_t) out.
// With XUNIT_W_GEN_VALID_EN defined, valid/last strobes are added to the bundle.
interface xunit_w_gen_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
);
  logic               run;
  logic [DATA_W-1:0]  in0;
  logic [DELAY_W-1:0] delay0;
  logic [DATA_W-1:0]  out0;
  logic [DATA_W-1:0]  out1;
`ifdef XUNIT_W_GEN_VALID_EN
  logic               valid;
  logic               last;

  modport master (
    output run, in0, delay0,
    input  out0, out1, valid, last
  );

  modport slave (
    input  run, in0, delay0,
    output out0, out1, valid, last
  );
`else
  modport master (
    output run, in0, delay0,
    input  out0, out1
  );

  modport slave (
    input  run, in0, delay0,
    output out0, out1
  );
`endif
endinterface

// File: rtl/xunit_w_gen.sv
// SHA-256 message-schedule source: streams 16 (W_t, K_t) pairs per run, four runs per block.
// Optional XUNIT_W_GEN_VALID_EN adds registered valid/last strobes on the bus.
module xunit_w_gen #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  xunit_w_gen_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         group_q, group_d;
  logic [3:0]         j_q, j_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DATA_W-1:0]  win_q [16];
  logic [DATA_W-1:0]  win_d [16];
  logic [DATA_W-1:0]  out0_q, out0_d;
  logic [DATA_W-1:0]  out1_q, out1_d;
  logic [DATA_W-1:0]  new_w;
`ifdef XUNIT_W_GEN_VALID_EN
  logic               valid_q, valid_d;
  logic               last_q, last_d;
`endif

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  // Group 0 passes the message word through; later groups expand from the window.
  assign new_w = (group_q == 2'd0) ? bus.in0
               : sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    j_d     = j_q;
    dly_d   = dly_q;
    win_d   = win_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
`ifdef XUNIT_W_GEN_VALID_EN
    valid_d = 1'b0;
    last_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          if (bus.delay0 != '0) begin
            dly_d   = bus.delay0;
            state_d = S_DELAY;
          end else begin
            state_d = S_ACTIVE;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == DELAY_W'(1)) begin
          dly_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          dly_d = dly_q - DELAY_W'(1);
        end
      end
      S_ACTIVE: begin
        for (int unsigned i = 0; i < 15; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[15] = new_w;
        out0_d    = new_w;
        out1_d    = k_rom({group_q, j_q});
`ifdef XUNIT_W_GEN_VALID_EN
        valid_d   = 1'b1;
        last_d    = (group_q == 2'd3) && (j_q == 4'd15);
`endif
        j_d = j_q + 4'd1;
        if (j_q == 4'd15) begin
          group_d = group_q + 2'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      group_q <= '0;
      j_q     <= '0;
      dly_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
`ifdef XUNIT_W_GEN_VALID_EN
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      j_q     <= j_d;
      dly_q   <= dly_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
`ifdef XUNIT_W_GEN_VALID_EN
      valid_q <= valid_d;
      last_q  <= last_d;
`endif
    end
  end

  assign bus.out0 = out0_q;
  assign bus.out1 = out1_q;
`ifdef XUNIT_W_GEN_VALID_EN
  assign bus.valid = valid_q;
  assign bus.last  = last_q;
`endif

endmodule

// File: doc/xunit_w_gen.md
Name: xunit_w_gen

Overview:
- Message-schedule source for the SHA-256 compression round unit (xunitF) in the Versat datapath.
- Per run, streams 16 consecutive (W_t, K_t) word pairs that drive the round unit's in8/in9 word and constant inputs.
- Four runs cover one 64-round block: the first run passes message words through and captures them; the next three expand them.
- Same run/delay0 configuration style as the other functional units.

Parameters:
- DATA_W, 32, word width; the block is defined only for 32.
- DELAY_W, 8, width of the delay0 configuration.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  one-cycle start pulse.
- in0  input  DATA_W  message word M_j; sampled only in group-0 ACTIVE cycles.
- delay0  input  DELAY_W  cycles to wait after run before the first ACTIVE cycle; latched at run.
- out0  output  DATA_W  registered W_t.
- out1  output  DATA_W  registered K_t.

Behaviour:
- Reset (rst=0, asynchronous):
  - out0=0, out1=0, 16-word window all 0.
  - State IDLE, group=0, round index j=0, delay counter=0.
  - Reset mid-operation aborts immediately; the next run starts at group 0.
- States and transitions:
  - IDLE: on run, latch delay0 and go to DELAY if delay0!=0, otherwise go to ACTIVE.
  - DELAY: count down the latched delay; go to ACTIVE in the cycle after the count reaches 1.
  - ACTIVE: exactly 16 cycles, j=0..15. After j=15: group <= (group+1) mod 4 (3 wraps to 0), then IDLE.
  - run in DELAY or ACTIVE is ignored; there is no restart and the group does not change.
- Timing:
  - Run asserted before posedge E0 with delay0=D: the first ACTIVE cycle is between posedges E0+D and E0+D+1.
  - W_(16*group) appears after posedge E0+D+1, giving latency 2 from the run edge when D=0. The next 15 words follow on consecutive cycles.
- Word generation in ACTIVE, with window w[0] oldest and w[15] newest:
  - group 0: new = in0.
  - groups 1-3: new = s1(w[14]) + w[9] + s0(w[1]) + w[0], modulo 2^32; carries are discarded.
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Each ACTIVE cycle: the window shifts left by one (w[i] <= w[i+1]), w[15] <= new, out0 <= new, out1 <= K[16*group + j].
- K is the 64-entry FIPS 180-4 constant ROM: K[0]=0x428a2f98, K[16]=0xe49b69c1, K[63]=0xc67178f2.
- Outside ACTIVE, out0/out1 hold their last values. The window persists between runs.

Optional Feature:
- Macro: XUNIT_W_GEN_VALID_EN.
- Defined:
  - Adds output port valid (1 bit), registered, reset 0.
  - valid=1 exactly in the 16 cycles when out0/out1 carry new ACTIVE data; 0 otherwise.
  - Adds output port last (1 bit), high together with valid on the word for j=15 of group 3, i.e. W_63.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset behaviour: drive rst low mid-ACTIVE during group 1 -> out0=0, out1=0 immediately. After release, run with D=0 and in0 stream 0x61626380 -> out0=0x61626380 two edges after run (group 0 restarted).
- "abc" block, D=0:
  - Run 1 with in0 = 0x61626380, fourteen 0x00000000, then 0x00000018 -> out0 echoes the 16 words; out1 = K[0..15], first 0x428a2f98.
  - Run 2 -> W16=0x61626380, W17=0x000f0000; out1 first=0xe49b69c1.
- Delay: run with delay0=5 -> first new out0 after edge E0+6; outputs hold for the 5 preceding cycles; 16 words on consecutive cycles.
- Group wrap: four runs -> fourth run's last out1 = 0xc67178f2. Fifth run samples in0 again (group 0 pass-through).
- Ignored run: pulse run at ACTIVE j=7 -> the stream continues unchanged to j=15 and the group advances by exactly 1.
- With XUNIT_W_GEN_VALID_EN: valid high for exactly 16 cycles per run; last high only on the W_63 cycle; valid low during the delay.
